fs_error_diffuser: RTL and testbench
====================================

FS_ERROR_DIFFUSER -- requirements
Module: fs_error_diffuser

Interface
REQ-001 Parameter IMAGEX, default 64: image width in pixels; SHALL be a power of two and at least 2.
REQ-002 Parameter IMAGEY, default 64: image height in pixels; SHALL be a power of two and at least 2.
REQ-003 Parameter RGB_SIZE, default 8: pixel width P (one channel, unsigned).
REQ-004 Parameter IMAGE_ADDR_WIDTH, default $clog2(IMAGEX*IMAGEY): pixel index and memory address width A.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 start  in  1  one-cycle request to dither one frame; accepted only in IDLE.
REQ-008 pixel_index  in  A  current raster index from the upstream pixel counter.
REQ-009 counter_en  out  1  one-cycle pulse that advances the upstream pixel counter.
REQ-010 busy  out  1  high from start acceptance until the DONE state is exited.
REQ-011 done  out  1  one-cycle pulse when the frame is complete.
REQ-012 mem_addr  out  A  frame-buffer address.
REQ-013 mem_rd  out  1  read strobe; mem_rdata is valid exactly one cycle later.
REQ-014 mem_wr  out  1  write strobe; writes mem_wdata to mem_addr at the same edge.
REQ-015 mem_wdata  out  P  write data.
REQ-016 mem_rdata  in  P  read data.

Function
REQ-017 Coordinates: x = pixel_index[log2(IMAGEX)-1:0]; y = the upper log2(IMAGEY) bits.
REQ-018 States: IDLE, RD_CUR, QNT_WR, N_RD, N_WR, ADV, DONE.
REQ-019 IDLE: start=1 -> RD_CUR and busy=1; start is ignored in every other state.
REQ-020 RD_CUR: mem_rd=1 with mem_addr=pixel_index -> QNT_WR.
REQ-021 QNT_WR: q = (mem_rdata >= 2^(P-1)) ? 2^P-1 : 0.
- Write q to pixel_index.
- Latch err = mem_rdata - q as a signed (P+1)-bit value.
- Go to N_RD for the first valid neighbour; go to ADV if there is none.
REQ-022 Neighbour order and weights: R (idx+1, 7), BL (idx+IMAGEX-1, 3), B (idx+IMAGEX, 5), BR (idx+IMAGEX+1, 1).
REQ-023 Skip rules:
- R and BR are skipped when x=IMAGEX-1.
- BL is skipped when x=0.
- BL, B and BR are skipped when y=IMAGEY-1.
REQ-024 N_RD: mem_rd=1 at the neighbour address -> N_WR.
REQ-025 N_WR: new = clamp(mem_rdata + ((err*w) >>> 4), 0, 2^P-1).
- The product is signed; the shift is arithmetic (floor toward minus infinity).
- Write new to the neighbour address.
- Go to N_RD for the next valid neighbour; go to ADV if there is none.
REQ-026 ADV: counter_en=1 for one cycle.
- If pixel_index = IMAGEX*IMAGEY-1 -> DONE (the counter wraps to 0).
- Otherwise -> RD_CUR.
REQ-027 DONE: done=1 for one cycle -> IDLE; busy=0 from the following cycle.
REQ-028 mem_rd and mem_wr SHALL never be asserted in the same cycle.
REQ-029 mem_rd, mem_wr and counter_en SHALL be 0 in IDLE and DONE.
REQ-030 Cycle cost per pixel = 3 + 2 x (number of valid neighbours).
- Interior pixel: 11 cycles.
- Final pixel: 3 cycles.
REQ-031 pixel_index SHALL be sampled only in RD_CUR, QNT_WR, N_RD and ADV; upstream holds it stable between counter_en pulses.

Reset
REQ-032 While rst=1: state=IDLE, busy=0, done=0, counter_en=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0, err=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately with no further memory access; a new start restarts from the current pixel_index.

Verification
REQ-034 4x4 image, all pixels 128, pixel 0 processed:
- write 255 to address 0;
- address 1 becomes 72 (delta -56);
- address 4 becomes 88 (delta -40);
- address 5 becomes 120 (delta -8);
- no BL access.
REQ-035 Saturation: pixel 127 with right neighbour 250 -> pixel written 0; err = +127; right neighbour written 255 (clamped from 305).
REQ-036 Boundary, 4x4: pixel at x=3, y=1 -> only BL (address 10) and B (address 11) accessed; 7 cycles from RD_CUR to ADV inclusive.
REQ-037 Full 4x4 frame:
- exactly 16 counter_en pulses;
- a single done pulse one cycle after the last ADV;
- pixel_index returns to 0;
- mem_rd and mem_wr are never high together.
REQ-038 Reset is asserted during N_WR of pixel 5 -> outputs take their reset values asynchronously; a later start with pixel_index=5 reprocesses pixel 5.
REQ-039 start pulsed while busy -> no effect on state, counter_en count or memory traffic.

Source files
------------

// File: rtl/fs_error_diffuser.sv
// fs_error_diffuser
//
// Floyd-Steinberg error diffusion over a single-channel frame buffer. For
// each pixel in raster order, the engine reads the pixel and writes back the
// value quantised to 0 or full scale. It then does a read-modify-write on each
// valid neighbour, adding the weighted quantisation error (R 7/16, BL 3/16,
// B 5/16, BR 1/16) and clamping to the pixel range. Finally it pulses
// counter_en so that the upstream raster counter advances.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           one-cycle request to dither a frame (honoured in IDLE only)
//   pixel_index     current raster index from the upstream counter
//   counter_en      one-cycle pulse that advances the upstream counter
//   busy            high from start acceptance until DONE is left
//   done            one-cycle pulse when the frame is complete
//   mem_addr        frame-buffer address
//   mem_rd          read strobe; mem_rdata is valid one cycle later
//   mem_wr          write strobe for mem_wdata at mem_addr
//   mem_wdata       write data
//   mem_rdata       read data
//
// state  | meaning
// IDLE   | waiting for start
// RD_CUR | read the current pixel
// QNT_WR | quantise, write back, latch the error
// N_RD   | read the selected neighbour
// N_WR   | write the neighbour plus its weighted error
// ADV    | advance the upstream pixel counter
// DONE   | one-cycle completion pulse

module fs_error_diffuser #(
  parameter int IMAGEX           = 64,
  parameter int IMAGEY           = 64,
  parameter int RGB_SIZE         = 8,
  parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGEX*IMAGEY)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [IMAGE_ADDR_WIDTH-1:0] pixel_index,
  output logic                        counter_en,
  output logic                        busy,
  output logic                        done,
  output logic [IMAGE_ADDR_WIDTH-1:0] mem_addr,
  output logic                        mem_rd,
  output logic                        mem_wr,
  output logic [RGB_SIZE-1:0]         mem_wdata,
  input  logic [RGB_SIZE-1:0]         mem_rdata
);

  localparam int A  = IMAGE_ADDR_WIDTH;
  localparam int P  = RGB_SIZE;
  localparam int XW = $clog2(IMAGEX);
  localparam int YW = $clog2(IMAGEY);

  localparam logic [XW-1:0] X_LAST   = XW'(IMAGEX-1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IMAGEY-1);
  localparam logic [A-1:0]  LAST_IDX = A'(IMAGEX*IMAGEY-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_CUR,
    S_QNT_WR,
    S_N_RD,
    S_N_WR,
    S_ADV,
    S_DONE
  } state_t;

  state_t state;

  // Error of the current pixel, signed (P+1) bits.
  logic signed [P:0] err;
  // Remaining neighbours still to be diffused; bit order R, BL, B, BR.
  logic [3:0]        rem;
  logic [A-1:0]      nb_addr;

  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [3:0]    nb_mask;
  logic [1:0]    nb_sel;
  logic [3:0]    rem_after;
  logic [A-1:0]  nb_offset;
  logic [A-1:0]  nb_addr_calc;
  logic [3:0]    weight;

  logic [P-1:0]      q;
  logic signed [P:0] err_new;

  logic signed [P+5:0] prod;
  logic signed [P+5:0] shifted;
  logic signed [P+5:0] sum;
  logic [P-1:0]        nb_new;

  assign px = pixel_index[XW-1:0];
  assign py = pixel_index[XW+YW-1:XW];

  always_comb begin
    nb_mask[0] = (px != X_LAST);
    nb_mask[1] = (px != '0) && (py != Y_LAST);
    nb_mask[2] = (py != Y_LAST);
    nb_mask[3] = (px != X_LAST) && (py != Y_LAST);
  end

  // Lowest remaining bit gives the next neighbour in R, BL, B, BR order.
  always_comb begin
    nb_sel = 2'd0;
    if (rem[0])      nb_sel = 2'd0;
    else if (rem[1]) nb_sel = 2'd1;
    else if (rem[2]) nb_sel = 2'd2;
    else if (rem[3]) nb_sel = 2'd3;
  end

  assign rem_after = rem & ~(4'b0001 << nb_sel);

  always_comb begin
    nb_offset = A'(1);
    weight    = 4'd7;
    case (nb_sel)
      2'd0: begin nb_offset = A'(1);        weight = 4'd7; end
      2'd1: begin nb_offset = A'(IMAGEX-1); weight = 4'd3; end
      2'd2: begin nb_offset = A'(IMAGEX);   weight = 4'd5; end
      default: begin nb_offset = A'(IMAGEX+1); weight = 4'd1; end
    endcase
  end

  assign nb_addr_calc = pixel_index + nb_offset;

  // Threshold at half scale: the MSB alone decides the quantised value.
  assign q       = {P{mem_rdata[P-1]}};
  assign err_new = $signed({1'b0, mem_rdata}) - $signed({1'b0, q});

  // Signed product, arithmetic shift (floor), then saturate to 0..2^P-1.
  assign prod    = $signed({{5{err[P]}}, err}) * $signed({{(P+2){1'b0}}, weight});
  assign shifted = prod >>> 4;
  assign sum     = $signed({6'b0, mem_rdata}) + shifted;

  always_comb begin
    if (sum[P+5])
      nb_new = '0;
    else if (|sum[P+4:P])
      nb_new = '1;
    else
      nb_new = sum[P-1:0];
  end

  // The address and write data depend on the current state and, for writes,
  // on read data that arrives in the same cycle. So these two are decoded
  // from the state and are not registered.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_RD_CUR: mem_addr = pixel_index;
      S_QNT_WR: begin
        mem_addr  = pixel_index;
        mem_wdata = q;
      end
      S_N_RD:   mem_addr = nb_addr_calc;
      S_N_WR: begin
        mem_addr  = nb_addr;
        mem_wdata = nb_new;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      counter_en <= 1'b0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      err        <= '0;
      rem        <= '0;
      nb_addr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_RD_CUR;
            busy   <= 1'b1;
            mem_rd <= 1'b1;
          end
        end
        S_RD_CUR: begin
          state  <= S_QNT_WR;
          mem_rd <= 1'b0;
          mem_wr <= 1'b1;
        end
        S_QNT_WR: begin
          err    <= err_new;
          rem    <= nb_mask;
          mem_wr <= 1'b0;
          if (|nb_mask) begin
            state  <= S_N_RD;
            mem_rd <= 1'b1;
          end else begin
            state      <= S_ADV;
            counter_en <= 1'b1;
          end
        end
        S_N_RD: begin
          nb_addr <= nb_addr_calc;
          state   <= S_N_WR;
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b1;
        end
        S_N_WR: begin
          rem    <= rem_after;
          mem_wr <= 1'b0;
          if (|rem_after) begin
            state  <= S_N_RD;
            mem_rd <= 1'b1;
          end else begin
            state      <= S_ADV;
            counter_en <= 1'b1;
          end
        end
        S_ADV: begin
          counter_en <= 1'b0;
          if (pixel_index == LAST_IDX) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state  <= S_RD_CUR;
            mem_rd <= 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fs_error_diffuser.sv
// Testbench for fs_error_diffuser on a 4x4 frame. It contains a frame-buffer
// model, an upstream pixel counter and a scoreboard of the expected writes and
// per-pixel cycle costs. The expected values come from a coordinate-based
// Floyd-Steinberg reference.

module tb_fs_error_diffuser;

  localparam int IX = 4, IY = 4, P = 8, A = 4, NPIX = IX*IY;

  logic         clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [A-1:0] pixel_index;
  logic         counter_en, busy, done, mem_rd, mem_wr;
  logic [A-1:0] mem_addr;
  logic [P-1:0] mem_wdata, mem_rdata;

  fs_error_diffuser #(.IMAGEX(IX), .IMAGEY(IY), .RGB_SIZE(P), .IMAGE_ADDR_WIDTH(A)) dut (
    .clk(clk), .rst(rst), .start(start), .pixel_index(pixel_index),
    .counter_en(counter_en), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic         ld_en = 1'b0;
  logic [A-1:0] ld_val = '0;
  always @(posedge clk) begin
    if (ld_en) pixel_index <= ld_val;
    else if (counter_en) pixel_index <= pixel_index + 1'b1;
  end

  logic [P-1:0] mem [NPIX];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  typedef struct { int addr; int data; int pix; } wr_t;
  wr_t exp_q[$];
  int  cost_q[$];
  wr_t wlog[$];
  wr_t mon_e;

  int n_cmp = 0, n_fail = 0;
  int ce_cnt = 0, done_cnt = 0, both_cnt = 0, rst_acc = 0, cyc = 0;
  int cost_seen [NPIX];
  bit prev_ce = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: walk the pixels by (x,y), apply the four weights to the
  // neighbours that lie inside the frame, and use floor division by 16.
  task automatic build_model(input int first);
    int img [NPIX];
    for (int i = 0; i < NPIX; i++) img[i] = int'(mem[i]);
    for (int idx = first; idx < NPIX; idx++) begin
      int x, y, old, qv, e, nv, dx, dy, w, n, t, d, v;
      x = idx % IX; y = idx / IX; old = img[idx]; nv = 0;
      qv = (old >= 128) ? 255 : 0;
      img[idx] = qv;
      exp_q.push_back('{idx, qv, idx});
      e = old - qv;
      for (int k = 0; k < 4; k++) begin
        case (k)
          0: begin dx = 1;  dy = 0; w = 7; end
          1: begin dx = -1; dy = 1; w = 3; end
          2: begin dx = 0;  dy = 1; w = 5; end
          default: begin dx = 1; dy = 1; w = 1; end
        endcase
        if (x + dx < 0 || x + dx >= IX || y + dy >= IY) continue;
        n = (y + dy) * IX + x + dx;
        t = e * w;
        d = (t >= 0) ? t / 16 : -((-t + 15) / 16);
        v = img[n] + d;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        img[n] = v;
        exp_q.push_back('{n, v, idx});
        nv++;
      end
      cost_q.push_back(3 + 2 * nv);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (mem_rd || mem_wr || counter_en) rst_acc++;
      cyc = 0;
      prev_ce = 1'b0;
    end else begin
      if (mem_rd && mem_wr) both_cnt++;
      if (mem_wr) begin
        wlog.push_back('{int'(mem_addr), int'(mem_wdata), int'(pixel_index)});
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", mem_addr, mon_e.addr);
          check("wr_data", mem_wdata, mon_e.data);
        end
      end
      if (busy) cyc++;
      if (counter_en) begin
        ce_cnt++;
        cost_seen[pixel_index] = cyc;
        if (cost_q.size() == 0) check("unexpected_adv", 1, 0);
        else check("pixel_cycles", cyc, cost_q.pop_front());
        cyc = 0;
      end
      if (done) begin
        done_cnt++;
        check("done_after_last_adv", prev_ce, 1);
        cyc = 0;
      end
      prev_ce = counter_en;
    end
  end

  task automatic fill_const(input int v);
    for (int i = 0; i < NPIX; i++) mem[i] = P'(v);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < NPIX; i++) mem[i] = P'($urandom_range(0, 255));
  endtask

  task automatic prepare(input int first);
    exp_q.delete(); cost_q.delete(); wlog.delete();
    build_model(first);
    ce_cnt = 0; done_cnt = 0; both_cnt = 0;
  endtask

  task automatic run_frame(input int first, input bit noisy);
    int guard;
    bit got_done;
    prepare(first);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0; got_done = 1'b0;
    while (!got_done && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (done) got_done = 1'b1;
      start = noisy && busy && !done && ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    check("done_seen", got_done, 1);
    @(negedge clk); @(negedge clk);
    check("counter_en_pulses", ce_cnt, NPIX - first);
    check("done_pulses", done_cnt, 1);
    check("index_wrapped", pixel_index, 0);
    check("exp_writes_left", exp_q.size(), 0);
    check("exp_costs_left", cost_q.size(), 0);
    check("rd_wr_overlap", both_cnt, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_counter_en"}, counter_en, 0);
    check({tag, "_mem_rd"}, mem_rd, 0);
    check({tag, "_mem_wr"}, mem_wr, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    int cnt, guard;
    int a7[$];
    bit hit;
    #1 rst = 1'b1;
    ld_en = 1'b1; ld_val = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    ld_en = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Uniform mid-grey frame: pixel 0 and the x=3,y=1 boundary pixel.
    fill_const(128);
    run_frame(0, 1'b0);
    cnt = 0;
    foreach (wlog[i]) if (wlog[i].pix == 0) cnt++;
    check("px0_nwrites", cnt, 4);
    if (wlog.size() >= 4) begin
      check("px0_w0_addr", wlog[0].addr, 0); check("px0_w0_data", wlog[0].data, 255);
      check("px0_w1_addr", wlog[1].addr, 1); check("px0_w1_data", wlog[1].data, 72);
      check("px0_w2_addr", wlog[2].addr, 4); check("px0_w2_data", wlog[2].data, 88);
      check("px0_w3_addr", wlog[3].addr, 5); check("px0_w3_data", wlog[3].data, 120);
    end else check("px0_log_size", wlog.size(), 4);
    foreach (wlog[i]) if (wlog[i].pix == 7) a7.push_back(wlog[i].addr);
    check("px7_nwrites", a7.size(), 3);
    if (a7.size() == 3) begin
      check("px7_addr0", a7[0], 7);
      check("px7_addr1", a7[1], 10);
      check("px7_addr2", a7[2], 11);
    end
    check("px7_cycles", cost_seen[7], 7);
    check("px15_cycles", cost_seen[15], 3);

    // Saturation of the right neighbour.
    fill_rand();
    mem[0] = 8'd127; mem[1] = 8'd250;
    run_frame(0, 1'b0);
    if (wlog.size() >= 2) begin
      check("sat_q_addr", wlog[0].addr, 0);  check("sat_q_data", wlog[0].data, 0);
      check("sat_r_addr", wlog[1].addr, 1);  check("sat_r_data", wlog[1].data, 255);
    end else check("sat_log_size", wlog.size(), 2);

    // Random frames, one with start pulsed while busy.
    fill_rand();
    run_frame(0, 1'b1);
    fill_rand();
    run_frame(0, 1'b0);

    // Abort during the first neighbour write of pixel 5, then restart there.
    fill_rand();
    prepare(0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0; hit = 1'b0;
    while (!hit && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (pixel_index == 5 && mem_wr && mem_addr != 5) hit = 1'b1;
    end
    check("abort_point_reached", hit, 1);
    #2 rst = 1'b1;
    #1 check_idle_outputs("abort");
    rst_acc = 0;
    repeat (2) @(negedge clk);
    check("access_during_reset", rst_acc, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_index_held", pixel_index, 5);
    run_frame(5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
